// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit turning core byte/half/word accesses into word-aligned bus transfers.
// Optional macro LSU_MISALIGN_EN adds misalignment trapping and the misalign_o output.
module riscv_lsu #(
  parameter int unsigned WAIT_LIMIT = 0,
  parameter bit          BE_ON_READ = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        bus_err_o,
`ifdef LSU_MISALIGN_EN
  output logic        misalign_o,
`endif
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam bit          TMO_EN = (WAIT_LIMIT != 0);
  localparam int unsigned CNT_W  = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TMO_EN ? WAIT_LIMIT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rd_q, rd_d;
  logic              bus_err_q, bus_err_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wd_q, mem_wd_d;
  logic              timeout_c;
  logic              misalign_c;
`ifdef LSU_MISALIGN_EN
  logic              misalign_q, misalign_d;
`endif

  function automatic logic is_byte(input logic [2:0] size);
    return (size == 3'd0) || (size == 3'd4);
  endfunction

  function automatic logic is_half(input logic [2:0] size);
    return (size == 3'd1) || (size == 3'd5);
  endfunction

  function automatic logic [3:0] calc_be(input logic [2:0] size, input logic [1:0] off);
    if (is_byte(size)) return 4'b0001 << off;
    if (is_half(size)) return off[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] calc_wd(input logic [2:0] size, input logic [31:0] wd);
    if (is_byte(size)) return {4{wd[7:0]}};
    if (is_half(size)) return {2{wd[15:0]}};
    return wd;
  endfunction

  // Lane selection by latched offset; signed sizes sign-extend, 4/5 zero-extend.
  function automatic logic [31:0] load_ext(input logic [2:0] size, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      3'd0:    return {{24{b[7]}}, b};
      3'd4:    return {24'h0, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'h0, h};
      default: return word;
    endcase
  endfunction

`ifdef LSU_MISALIGN_EN
  assign misalign_c = (is_half(core_size_i) && core_addr_i[0]) ||
                      (!is_byte(core_size_i) && !is_half(core_size_i) &&
                       (core_addr_i[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  assign timeout_c = TMO_EN && (cnt_q == CNT_MAX) && !mem_ready_i;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (core_req_i) state_d = misalign_c ? DONE : BUSY;
      BUSY:    if (mem_ready_i || timeout_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    we_d       = we_q;
    size_d     = size_q;
    off_d      = off_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    bus_err_d  = 1'b0;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_be_d   = mem_be_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
`ifdef LSU_MISALIGN_EN
    misalign_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (core_req_i) begin
          we_d   = core_we_i;
          size_d = core_size_i;
          off_d  = core_addr_i[1:0];
          if (misalign_c) begin
            rd_d = '0;
`ifdef LSU_MISALIGN_EN
            misalign_d = 1'b1;
`endif
          end else begin
            mem_req_d  = 1'b1;
            mem_we_d   = core_we_i;
            mem_be_d   = (core_we_i || BE_ON_READ) ? calc_be(core_size_i, core_addr_i[1:0])
                                                   : 4'b1111;
            mem_addr_d = {core_addr_i[31:2], 2'b00};
            mem_wd_d   = calc_wd(core_size_i, core_wd_i);
          end
        end
      end
      BUSY: begin
        if (mem_ready_i) begin
          mem_req_d = 1'b0;
          if (!we_q) rd_d = load_ext(size_q, off_q, mem_rd_i);
        end else if (timeout_c) begin
          mem_req_d = 1'b0;
          rd_d      = '0;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q       <= 1'b0;
      size_q     <= '0;
      off_q      <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      bus_err_q  <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_be_q   <= '0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
`ifdef LSU_MISALIGN_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      we_q       <= we_d;
      size_q     <= size_d;
      off_q      <= off_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      bus_err_q  <= bus_err_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_be_q   <= mem_be_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
`ifdef LSU_MISALIGN_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign core_stall_o = core_req_i && (state_q != DONE);
  assign core_rd_o    = rd_q;
  assign bus_err_o    = bus_err_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_be_o     = mem_be_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wd_o     = mem_wd_q;
`ifdef LSU_MISALIGN_EN
  assign misalign_o   = misalign_q;
`endif

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: randomized transaction-level check of riscv_lsu against a byte-lane reference model.
// Instance 0: no timeout, byte enables on reads. Instance 1: WAIT_LIMIT=4, full enables on reads.
module tb_riscv_lsu;

  localparam int N   = 2;
  localparam int WL1 = 4;

  logic clk = 1'b0;
  logic rst;

  logic        req[N], we[N], rdy[N];
  logic [2:0]  size[N];
  logic [31:0] addr[N], wd[N], mrd[N];
  logic [31:0] rd_o[N], maddr[N], mwd[N];
  logic        stall[N], berr[N], mreq[N], mwe[N];
  logic [3:0]  mbe[N];
`ifdef LSU_MISALIGN_EN
  logic        mis[N];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  riscv_lsu #(.WAIT_LIMIT(0), .BE_ON_READ(1'b1)) u_lsu0 (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(req[0]), .core_we_i(we[0]), .core_size_i(size[0]),
    .core_addr_i(addr[0]), .core_wd_i(wd[0]), .core_rd_o(rd_o[0]),
    .core_stall_o(stall[0]), .bus_err_o(berr[0]),
`ifdef LSU_MISALIGN_EN
    .misalign_o(mis[0]),
`endif
    .mem_req_o(mreq[0]), .mem_we_o(mwe[0]), .mem_be_o(mbe[0]),
    .mem_addr_o(maddr[0]), .mem_wd_o(mwd[0]), .mem_rd_i(mrd[0]),
    .mem_ready_i(rdy[0])
  );

  riscv_lsu #(.WAIT_LIMIT(WL1), .BE_ON_READ(1'b0)) u_lsu1 (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(req[1]), .core_we_i(we[1]), .core_size_i(size[1]),
    .core_addr_i(addr[1]), .core_wd_i(wd[1]), .core_rd_o(rd_o[1]),
    .core_stall_o(stall[1]), .bus_err_o(berr[1]),
`ifdef LSU_MISALIGN_EN
    .misalign_o(mis[1]),
`endif
    .mem_req_o(mreq[1]), .mem_we_o(mwe[1]), .mem_be_o(mbe[1]),
    .mem_addr_o(maddr[1]), .mem_wd_o(mwd[1]), .mem_rd_i(mrd[1]),
    .mem_ready_i(rdy[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: access width in bytes and the byte lane it occupies.
  function automatic int nbytes(input logic [2:0] s);
    if (s == 3'd0 || s == 3'd4) return 1;
    if (s == 3'd1 || s == 3'd5) return 2;
    return 4;
  endfunction

  function automatic int lane(input logic [2:0] s, input logic [31:0] a);
    int n = nbytes(s);
    int lo = int'(a % 32'd4);
    return (lo / n) * n;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] s, input logic [31:0] a);
    int n = nbytes(s);
    return 4'(((1 << n) - 1) << lane(s, a));
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] s, input logic [31:0] d);
    int n = nbytes(s);
    if (n == 1) return (d % 32'h100) * 32'h0101_0101;
    if (n == 2) return (d % 32'h1_0000) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [2:0] s, input logic [31:0] a,
                                         input logic [31:0] w);
    int n = nbytes(s);
    longint unsigned v, span;
    span = 64'd1 << (8 * n);
    v = (64'(w) >> (8 * lane(s, a))) % span;
    if ((s == 3'd0 || s == 3'd1) && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  function automatic bit misaligned(input logic [2:0] s, input logic [31:0] a);
    int n = nbytes(s);
    return (n > 1) && ((a % 32'(n)) != 0);
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete access on instance i, starting and ending in an IDLE cycle at negedge.
  task automatic do_access(input int i, input logic w, input logic [2:0] s,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] word, input int waits, input bit drop);
    int       wl = (i == 0) ? 0 : WL1;
    bit       tmo = (wl > 0) && (waits >= wl);
    int       busy_n = tmo ? wl : waits + 1;
    bit       mis_exp = 1'b0;
    logic [3:0] be_e = (w || i == 0) ? exp_be(s, a) : 4'hF;
`ifdef LSU_MISALIGN_EN
    mis_exp = misaligned(s, a);
`endif
    req[i] = 1'b1; we[i] = w; size[i] = s; addr[i] = a; wd[i] = d;
    rdy[i] = 1'b0; mrd[i] = $urandom;
    #1 chk("idle_stall", 32'(stall[i]), 1);
    cyc();
    if (!mis_exp) begin
      for (int k = 0; k < busy_n; k++) begin
        if (drop && k == 1) req[i] = 1'b0;
        rdy[i] = !tmo && (k == waits);
        mrd[i] = rdy[i] ? word : $urandom;
        #1;
        chk("busy_req",   32'(mreq[i]), 1);
        chk("busy_we",    32'(mwe[i]), 32'(w));
        chk("busy_addr",  maddr[i], a - (a % 32'd4));
        chk("busy_be",    32'(mbe[i]), 32'(be_e));
        chk("busy_wd",    mwd[i], exp_wd(s, d));
        chk("busy_stall", 32'(stall[i]), (drop && k >= 1) ? 0 : 1);
        chk("busy_berr",  32'(berr[i]), 0);
        cyc();
      end
    end
    rdy[i] = 1'b0;
    #1;
    chk("done_stall", 32'(stall[i]), 0);
    chk("done_req",   32'(mreq[i]), 0);
    chk("done_berr",  32'(berr[i]), 32'(tmo));
`ifdef LSU_MISALIGN_EN
    chk("done_mis",   32'(mis[i]), 32'(mis_exp));
`endif
    if (tmo || mis_exp) chk("done_rd_zero", rd_o[i], 0);
    else if (!w)        chk("done_rd", rd_o[i], exp_rd(s, a, word));
    req[i] = 1'b0;
    cyc();
    chk("post_stall", 32'(stall[i]), 0);
    chk("post_berr",  32'(berr[i]), 0);
    chk("post_req",   32'(mreq[i]), 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; rdy[i] = 1'b0; size[i] = '0;
      addr[i] = '0; wd[i] = '0; mrd[i] = '0;
    end
    cyc();
    #1;
    for (int i = 0; i < N; i++) begin
      chk("rst_req",   32'(mreq[i]), 0);
      chk("rst_we",    32'(mwe[i]), 0);
      chk("rst_be",    32'(mbe[i]), 0);
      chk("rst_addr",  maddr[i], 0);
      chk("rst_wd",    mwd[i], 0);
      chk("rst_berr",  32'(berr[i]), 0);
      chk("rst_rd",    rd_o[i], 0);
      chk("rst_stall", 32'(stall[i]), 0);
    end
    rst = 1'b0;
    cyc();

    // Directed cases
    do_access(0, 1'b1, 3'd0, 32'h0000_1003, 32'hAABB_CCDD, 32'h0, 0, 1'b0);
    do_access(0, 1'b0, 3'd0, 32'h0000_2001, 32'h0, 32'h12F0_8034, 0, 1'b0);
    do_access(0, 1'b0, 3'd4, 32'h0000_2001, 32'h0, 32'h12F0_8034, 0, 1'b0);
    do_access(0, 1'b0, 3'd1, 32'h0000_2002, 32'h0, 32'h12F0_8034, 0, 1'b0);
    do_access(0, 1'b0, 3'd2, 32'h0000_2000, 32'h0, 32'hCAFE_F00D, 5, 1'b0);
    do_access(1, 1'b0, 3'd2, 32'h0000_5000, 32'h0, 32'h1234_5678, 20, 1'b0);
    do_access(1, 1'b0, 3'd5, 32'h0000_5002, 32'h0, 32'h8765_4321, 3, 1'b0);
    do_access(0, 1'b0, 3'd0, 32'h0000_6002, 32'h0, 32'h0055_0000, 2, 1'b1);
    do_access(0, 1'b0, 3'd2, 32'h0000_3002, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);

    // Reset in the middle of a BUSY cycle
    req[0] = 1'b1; we[0] = 1'b0; size[0] = 3'd2; addr[0] = 32'h0000_4000;
    cyc();
    #1 chk("rstb_req", 32'(mreq[0]), 1);
    rst = 1'b1;
    #1;
    chk("rstm_req",   32'(mreq[0]), 0);
    chk("rstm_stall", 32'(stall[0]), 1);
    chk("rstm_rd",    rd_o[0], 0);
    req[0] = 1'b0;
    #1 chk("rstm_stall0", 32'(stall[0]), 0);
    cyc();
    rst = 1'b0;
    cyc();

    // Randomized accesses on both instances
    for (int t = 0; t < 300; t++) begin
      int          i  = int'($urandom_range(0, 1));
      logic [2:0]  s  = 3'($urandom_range(0, 7));
      int          wt = int'($urandom_range(0, 6));
      bit          dr = ($urandom_range(0, 7) == 0) && (wt >= 1);
      do_access(i, 1'($urandom_range(0, 1)), s, $urandom, $urandom, $urandom, wt, dr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit: the responder for the core's data-memory request interface (`mem_req`/`mem_we`/`mem_size`/`mem_addr`/`mem_wd` in, `mem_rd`/`stall` out).
- Holds the core stalled while a transaction is outstanding.
- Converts byte/halfword/word accesses into word-aligned bus transfers with byte enables, and sign- or zero-extends load data.
- Sits between `riscv_core` and the data memory / peripheral bus.

Parameters:
- WAIT_LIMIT, 0, maximum BUSY cycles without `mem_ready_i` before abort; 0 disables the timeout.
- BE_ON_READ, 1, 1: drive the size/offset byte-enable pattern on reads; 0: drive 4'b1111 on reads.

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  reset, asynchronous, active-high
- core_req_i  input  1  core requests a memory access
- core_we_i  input  1  1 = store, 0 = load
- core_size_i  input  3  0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU
- core_addr_i  input  32  byte address
- core_wd_i  input  32  store data (LSBs significant)
- core_rd_o  output  32  extended load data
- core_stall_o  output  1  to core `stall_i`
- bus_err_o  output  1  one-cycle pulse: timeout abort
- mem_req_o  output  1  bus request
- mem_we_o  output  1  bus write
- mem_be_o  output  4  byte enables
- mem_addr_o  output  32  word-aligned address {addr[31:2],2'b00}
- mem_wd_o  output  32  replicated store data
- mem_rd_i  input  32  bus read word
- mem_ready_i  input  1  bus completes the transfer this cycle

Behaviour:
- **Reset:** FSM goes to IDLE immediately. Registered outputs `mem_req_o`, `mem_we_o`, `mem_be_o`, `mem_addr_o`, `mem_wd_o`, `bus_err_o` reset to 0. The captured read word and wait counter also reset to 0, so `core_rd_o` = 0 after reset.
- **Abandoned request:** reset mid-BUSY drops `mem_req_o` without waiting for ready. The bus must tolerate an abandoned request.
- **Stall:** `core_stall_o` = `core_req_i` & (state != DONE). It is combinational, so it rises in the same cycle as the request.
- **IDLE state:**
  - If `core_req_i`: latch we, size, addr[1:0] and address.
  - Compute be/wd and register them onto the bus outputs.
  - Go to BUSY.
- **BUSY state:**
  - `mem_req_o` = 1; all bus outputs are held stable.
  - On `mem_ready_i`: capture `mem_rd_i` (loads), then go to DONE.
  - If WAIT_LIMIT > 0 and the counter reaches WAIT_LIMIT with no ready: go to DONE, set the read word to 0, pulse `bus_err_o` in DONE.
- **DONE state:**
  - Stall is 0 and `core_rd_o` is valid; `mem_req_o` = 0.
  - Go to IDLE next cycle, unconditionally.
- **Latency:** minimum 3 cycles per access: IDLE, BUSY with ready, DONE. Back-to-back requests therefore start in the IDLE cycle following DONE.
- **Request withdrawn:** if `core_req_i` drops while BUSY, the transfer still completes and the data is discarded. No abort.
- **Byte enables:**
  - SB: be = 4'b0001 << addr[1:0].
  - SH: be = addr[1] ? 4'b1100 : 4'b0011.
  - SW: be = 4'b1111.
  - Loads follow the same pattern per BE_ON_READ.
- **Store data:** SB: {4{wd[7:0]}}; SH: {2{wd[15:0]}}; SW: wd.
- **Load extraction:** the byte or halfword is selected by the latched addr[1:0] / addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- **Invalid sizes:** sizes 3, 6 and 7 are handled as word access.

Optional Feature:
- Macro: LSU_MISALIGN_EN. Adds output `misalign_o` (1 bit, reset 0).
- **Defined:**
  - A halfword with addr[0]=1, or a word with addr[1:0]!=0, is misaligned.
  - A misaligned access goes IDLE -> DONE directly with no bus request.
  - `misalign_o` pulses in DONE, `core_rd_o` = 0, and nothing is written.
- **Undefined:** there is no check and no port. The unused low bits are ignored: halfword uses addr[1], word uses the aligned word.

Test Plan:
- **SB:** `core_addr_i`=0x1003, `core_wd_i`=0xAABBCCDD, size 0, we=1, ready after 1 BUSY cycle -> `mem_addr_o`=0x1000, `mem_be_o`=4'b1000, `mem_wd_o`=0xDDDDDDDD. Stall high for 2 cycles, low in the 3rd.
- **LB/LBU:** `core_addr_i`=0x2001, `mem_rd_i`=0x12F0_8034, ready immediate -> LB gives `core_rd_o`=0xFFFFFF80; LBU gives 0x00000080.
- **LH:** `core_addr_i`=0x2002 with the same word -> LH gives 0x000012F0; `mem_be_o`=4'b1100 when BE_ON_READ=1.
- **Wait states:** ready held low 5 cycles with WAIT_LIMIT=0 -> `mem_req_o` and address stable for all 5 cycles. Stall stays high until the DONE cycle; `core_rd_o` matches `mem_rd_i` sampled at ready.
- **Timeout:** WAIT_LIMIT=4, ready never asserted -> DONE after 4 BUSY cycles, `bus_err_o`=1 for one cycle, `core_rd_o`=0.
- **Reset mid-BUSY:** assert `rst_i` during BUSY -> `mem_req_o`=0 and stall follows `core_req_i` from IDLE. With LSU_MISALIGN_EN, LW at 0x3002 gives `misalign_o`=1, no `mem_req_o`, `core_rd_o`=0.
